fetch_unit: RTL and testbench

Instruction-fetch front end of the single-cycle/CSR core. Owns the program counter, drives the byte address into the asynchronous word-addressed instruction memory, and captures the returned word with its PC into a small FIFO. The FIFO feeds the decoder through a valid/ready handshake. Execute/CSR logic redirects it for branches, jumps, traps and `mret`.

---
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//
// Owns the program counter, presents it as a byte address to an asynchronous
// word-addressed instruction memory, and queues {pc, word} pairs in a small
// FIFO that feeds the decoder over a valid/ready handshake. Execute/CSR logic
// restarts fetch through a one-cycle redirect that also flushes the FIFO.
//
// Optional build macro: FETCH_MISALIGN_TRAP_EN
//   defined   - a redirect to a non-word-aligned target halts fetch and raises
//               misalign_err (registered) until an aligned redirect or reset.
//   undefined - redirect_pc[1:0] is ignored (forced to 2'b00), misalign_err = 0.
//
// Parameters:
//   RESET_PC        fetch address after reset (word-aligned)
//   DEPTH           FIFO entries (power of two, >= 2)
//
// Ports:
//   clk             sole clock, rising edge
//   rst             synchronous active-high reset
//   imem_addr       byte address to instruction memory (current fetch pc)
//   imem_data       instruction word at imem_addr, same cycle
//   redirect_valid  one-cycle request to restart fetch at redirect_pc
//   redirect_pc     new fetch target
//   inst_valid      FIFO head holds an instruction
//   inst_ready      decoder accepts head this cycle
//   inst_out        head instruction word
//   inst_pc         pc of head instruction
//   fifo_count      occupied FIFO entries
//   misalign_err    fetch halted on a misaligned target

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [31:0]                  imem_addr,
    input  logic [31:0]                  imem_data,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [31:0]                  inst_out,
    output logic [31:0]                  inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         misalign_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0]     head_q, head_d;
    logic [PtrW-1:0]     tail_q, tail_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [31:0]         entry_pc_q   [DEPTH];
    logic [31:0]         entry_pc_d   [DEPTH];
    logic [31:0]         entry_word_q [DEPTH];
    logic [31:0]         entry_word_d [DEPTH];

    logic                halted;
    logic                pop;
    logic                push;
    logic [31:0]         redirect_tgt;
    logic                redirect_mis;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_tgt = redirect_pc;
    assign redirect_mis = |redirect_pc[1:0];
    // Registered: goes high the cycle after the misaligned redirect.
    assign misalign_err = (state_q == StHalt);
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign redirect_mis = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign halted     = (state_q == StHalt);
    assign imem_addr  = fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst_out   = entry_word_q[head_q];
    assign inst_pc    = entry_pc_q[head_q];
    assign fifo_count = count_q;

    assign pop  = inst_valid & inst_ready;
    // A pop frees the head slot this cycle, so a full FIFO can still accept.
    assign push = !halted & !redirect_valid & ((count_q < DepthC) | pop);

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        entry_pc_d   = entry_pc_q;
        entry_word_d = entry_word_q;

        if (redirect_valid) begin
            // Flush wins over any same-cycle push or pop.
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = redirect_tgt;
            state_d    = redirect_mis ? StHalt : StRun;
        end else begin
            if (push) begin
                entry_pc_d[tail_q]   = fetch_pc_q;
                entry_word_d[tail_q] = imem_data;
                tail_d               = tail_q + PtrW'(1);
                fetch_pc_d           = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            fetch_pc_q   <= RESET_PC;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            entry_pc_q   <= '{default: '0};
            entry_word_q <= '{default: '0};
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            entry_pc_q   <= entry_pc_d;
            entry_word_q <= entry_word_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.

module tb_fetch_unit;

    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam int unsigned Depth   = 2;

    logic                         clk;
    logic                         rst;
    logic [31:0]                  imem_addr;
    logic [31:0]                  imem_data;
    logic                         redirect_valid;
    logic [31:0]                  redirect_pc;
    logic                         inst_valid;
    logic                         inst_ready;
    logic [31:0]                  inst_out;
    logic [31:0]                  inst_pc;
    logic [$clog2(Depth+1)-1:0]   fifo_count;
    logic                         misalign_err;

    fetch_unit #(
        .RESET_PC (ResetPc),
        .DEPTH    (Depth)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .fifo_count     (fifo_count),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: an address-dependent word so lost or duplicated
    // entries are visible in inst_out as well as inst_pc.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, a[31:16]} ^ 32'h0000_0013;
    endfunction

    assign imem_data = mem_word(imem_addr);

    // Reference model state.
    logic [31:0] q_pc[$];
    logic [31:0] q_word[$];
    logic [31:0] m_pc;
    logic        m_halt;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_word.delete();
        m_pc   = ResetPc;
        m_halt = 1'b0;
    endtask

    // One clock: compare outputs, apply inputs, advance model, step past the edge.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc,
                         input logic rdy);
        bit pop;
        bit push;
        check("imem_addr", imem_addr, m_pc);
        check("inst_valid", 32'(inst_valid), 32'(q_pc.size() != 0));
        check("fifo_count", 32'(fifo_count), 32'(q_pc.size()));
        check("misalign_err", 32'(misalign_err), 32'(m_halt));
        if (q_pc.size() != 0) begin
            check("inst_pc", inst_pc, q_pc[0]);
            check("inst_out", inst_out, q_word[0]);
        end

        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;

        if (r) begin
            model_reset();
        end else if (rv) begin
            q_pc.delete();
            q_word.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc   = rpc;
            m_halt = (rpc[1:0] != 2'b00);
`else
            m_pc   = rpc & 32'hFFFF_FFFC;
            m_halt = 1'b0;
`endif
        end else begin
            pop  = (q_pc.size() != 0) && rdy;
            push = !m_halt && ((q_pc.size() < Depth) || pop);
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_word.pop_front());
            end
            if (push) begin
                q_pc.push_back(m_pc);
                q_word.push_back(mem_word(m_pc));
                m_pc = m_pc + 32'd4;
            end
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rpc;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        check("reset_inst_out", inst_out, 32'h0);
        check("reset_inst_pc", inst_pc, 32'h0);

        // Streaming with the decoder always ready.
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        // Stall: FIFO fills and fetch pc freezes.
        repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        // Release: drain in order while pushing.
        repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        // Fill to full then redirect with entries queued.
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        // Address wrap.
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        // Misaligned targets, then an aligned one.
        cycle(1'b0, 1'b1, 32'h0000_0042, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0047, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0044, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        // Reset overrides a same-cycle redirect.
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0080, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 4) == 0) rpc[31:5] = '1;
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0), rpc,
                  ($urandom_range(0, 9) < 7));
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
